// File: rtl/oled_spi_arbiter.sv
// ---------------------------------------------------------------------------
// oled_spi_arbiter
//   Owns the single write-only SPI Mode 3 link to an SSD1331 OLED and shares
//   it between a command requester (D/C low) and a pixel-data requester
//   (D/C high). Each accepted burst is framed in one CS-low window and
//   serialised MSB-first. SCK idles high, MOSI changes on the SCK falling edge
//   and the slave samples on the rising edge.
//
// Parameters
//   CLK_DIV    sclk cycles per SCK half-period (>= 1)
//   CS_GAP     sclk cycles CS is held high between bursts (>= 1)
//
// Ports
//   sclk        system clock
//   rst         synchronous active-high reset
//   cmd_valid   command byte available
//   cmd_data    command byte
//   cmd_last    final byte of the command burst
//   cmd_ready   command byte accepted this cycle (combinational)
//   dat_valid   pixel byte available
//   dat_data    pixel byte
//   dat_last    final byte of the pixel burst
//   dat_ready   pixel byte accepted this cycle (combinational)
//   cs          SPI chip select, active low (registered)
//   spi_sck     SPI clock, idles high (registered)
//   mosi        SPI data (registered)
//   dc_c        0 = command, 1 = data (registered)
//   busy        high whenever the arbiter is not idle (registered)
// ---------------------------------------------------------------------------
module oled_spi_arbiter #(
  parameter int unsigned CLK_DIV = 8,
  parameter int unsigned CS_GAP  = 4
) (
  input  logic       sclk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  input  logic       cmd_last,
  output logic       cmd_ready,
  input  logic       dat_valid,
  input  logic [7:0] dat_data,
  input  logic       dat_last,
  output logic       dat_ready,
  output logic       cs,
  output logic       spi_sck,
  output logic       mosi,
  output logic       dc_c,
  output logic       busy
);

  // Divider counter is shared by the SETUP, SHIFT and GAP phases.
  localparam int unsigned DIV_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int unsigned DIV_W   = $clog2(DIV_MAX + 1);
  localparam logic [DIV_W-1:0] DIV_END = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] GAP_END = DIV_W'(CS_GAP - 1);

  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("oled_spi_arbiter: CLK_DIV must be at least 1");
  end
  if (CS_GAP < 1) begin : g_bad_cs_gap
    $error("oled_spi_arbiter: CS_GAP must be at least 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_NEXT  = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

  state_e           state_q;
  logic [DIV_W-1:0] div_q;
  logic [2:0]       bit_q;
  logic [7:0]       shreg_q;
  logic             last_q;
  logic             grant_q;
  logic             cs_q;
  logic             sck_q;
  logic             mosi_q;
  logic             dc_q;
  logic             busy_q;

  logic             acc_c;
  logic [7:0]       acc_data_c;
  logic             acc_last_c;

  // Ready pulses: fixed priority in IDLE, only the granted channel in NEXT.
  assign cmd_ready = !rst && cmd_valid &&
                     ((state_q == ST_IDLE) || ((state_q == ST_NEXT) && !grant_q));
  assign dat_ready = !rst && dat_valid &&
                     (((state_q == ST_IDLE) && !cmd_valid) ||
                      ((state_q == ST_NEXT) && grant_q));

  assign acc_c      = cmd_ready | dat_ready;
  assign acc_data_c = cmd_ready ? cmd_data : dat_data;
  assign acc_last_c = cmd_ready ? cmd_last : dat_last;

  // Link state machine; every pin is a register updated here.
  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      bit_q   <= 3'd0;
      shreg_q <= 8'h00;
      last_q  <= 1'b0;
      grant_q <= 1'b0;
      cs_q    <= 1'b1;
      sck_q   <= 1'b1;
      mosi_q  <= 1'b0;
      dc_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (acc_c) begin
            // The only place dc changes: CS is still high this cycle.
            grant_q <= dat_ready;
            dc_q    <= dat_ready;
            shreg_q <= acc_data_c;
            last_q  <= acc_last_c;
            mosi_q  <= acc_data_c[7];
            cs_q    <= 1'b0;
            div_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SETUP;
          end
        end

        // CS setup time with SCK high and the first data bit already on MOSI.
        ST_SETUP: begin
          if (div_q == DIV_END) begin
            div_q   <= '0;
            bit_q   <= 3'd7;
            sck_q   <= 1'b0;
            state_q <= ST_SHIFT;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end

        // sck_q doubles as the phase flag: low phase then high phase per bit.
        ST_SHIFT: begin
          if (div_q != DIV_END) begin
            div_q <= div_q + DIV_W'(1);
          end else begin
            div_q <= '0;
            if (!sck_q) begin
              sck_q <= 1'b1;
            end else if (bit_q != 3'd0) begin
              // Falling edge: present the next bit.
              bit_q   <= bit_q - 3'd1;
              sck_q   <= 1'b0;
              mosi_q  <= shreg_q[6];
              shreg_q <= {shreg_q[6:0], 1'b0};
            end else if (last_q) begin
              cs_q    <= 1'b1;
              state_q <= ST_GAP;
            end else begin
              state_q <= ST_NEXT;
            end
          end
        end

        // Hold CS low with SCK high until the granted requester supplies more.
        ST_NEXT: begin
          if (acc_c) begin
            shreg_q <= acc_data_c;
            last_q  <= acc_last_c;
            mosi_q  <= acc_data_c[7];
            sck_q   <= 1'b0;
            bit_q   <= 3'd7;
            div_q   <= '0;
            state_q <= ST_SHIFT;
          end
        end

        // CS high recovery between bursts.
        ST_GAP: begin
          if (div_q == GAP_END) begin
            div_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end

        default: begin
          state_q <= ST_IDLE;
          cs_q    <= 1'b1;
          sck_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cs      = cs_q;
  assign spi_sck = sck_q;
  assign mosi    = mosi_q;
  assign dc_c    = dc_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_oled_spi_arbiter.sv
// ---------------------------------------------------------------------------
// tb_oled_spi_arbiter
//   Requester drivers feed per-channel byte queues into the arbiter. A pin
//   monitor decodes the SPI link into bursts (dc, bytes, timing) and checks
//   them against the bytes each requester queued, plus timing rules of the
//   link (half-period widths, CS setup, CS gap, stable dc inside a burst).
// ---------------------------------------------------------------------------
module tb_oled_spi_arbiter;

  localparam int CLK_DIV = 2;
  localparam int CS_GAP  = 2;

  logic       sclk = 1'b0;
  logic       rst  = 1'b1;
  logic       cmd_valid, cmd_last, cmd_ready;
  logic [7:0] cmd_data;
  logic       dat_valid, dat_last, dat_ready;
  logic [7:0] dat_data;
  logic       cs, spi_sck, mosi, dc_c, busy;

  always #5 sclk = ~sclk;

  oled_spi_arbiter #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
    .sclk      (sclk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_data  (cmd_data),
    .cmd_last  (cmd_last),
    .cmd_ready (cmd_ready),
    .dat_valid (dat_valid),
    .dat_data  (dat_data),
    .dat_last  (dat_last),
    .dat_ready (dat_ready),
    .cs        (cs),
    .spi_sck   (spi_sck),
    .mosi      (mosi),
    .dc_c      (dc_c),
    .busy      (busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Driver items carry the idle cycles to wait before presenting the byte.
  typedef struct packed { logic [7:0] data; logic last; logic [7:0] gap; } item_t;
  typedef struct packed { logic [7:0] data; logic last; } exp_t;
  typedef struct { logic dc; int nbytes; int cs_low; logic [7:0] first; int max_high; } burst_t;

  item_t  cmd_drv[$], dat_drv[$];
  exp_t   cmd_exp[$], dat_exp[$];
  burst_t burst_log[$];

  task automatic push_item(input int ch, input logic [7:0] d, input logic l, input int g);
    item_t it;
    exp_t  e;
    it.data = d; it.last = l; it.gap = 8'(g);
    e.data  = d; e.last  = l;
    if (ch == 0) begin cmd_drv.push_back(it); cmd_exp.push_back(e); end
    else         begin dat_drv.push_back(it); dat_exp.push_back(e); end
  endtask

  // Requester drivers: present queued bytes, hold until accepted.
  logic cmd_fire_n = 1'b0, dat_fire_n = 1'b0;
  int   cmd_wait = 0, dat_wait = 0;

  initial begin
    cmd_valid = 1'b0; cmd_data = 8'h00; cmd_last = 1'b0;
    dat_valid = 1'b0; dat_data = 8'h00; dat_last = 1'b0;
    forever begin
      @(posedge sclk);
      #1;
      if (cmd_fire_n) begin
        cmd_valid = 1'b0;
        if (cmd_drv.size() > 0) void'(cmd_drv.pop_front());
        cmd_wait = 0;
      end
      if (dat_fire_n) begin
        dat_valid = 1'b0;
        if (dat_drv.size() > 0) void'(dat_drv.pop_front());
        dat_wait = 0;
      end
      if (!cmd_valid && cmd_drv.size() > 0) begin
        if (cmd_wait >= int'(cmd_drv[0].gap)) begin
          cmd_valid = 1'b1; cmd_data = cmd_drv[0].data; cmd_last = cmd_drv[0].last; cmd_wait = 0;
        end else cmd_wait++;
      end
      if (!dat_valid && dat_drv.size() > 0) begin
        if (dat_wait >= int'(dat_drv[0].gap)) begin
          dat_valid = 1'b1; dat_data = dat_drv[0].data; dat_last = dat_drv[0].last; dat_wait = 0;
        end else dat_wait++;
      end
    end
  end

  // Pin monitor: decodes bursts and checks link timing and byte order.
  logic       prev_cs = 1'b1, prev_sck = 1'b1, prev_mosi = 1'b0;
  logic       in_burst = 1'b0, burst_dc = 1'b0, expect_end = 1'b0;
  logic       cs_fall, cs_rise, sck_rise, sck_fall;
  logic [7:0] shift = 8'h00, first_byte = 8'h00;
  int         nbits = 0, nbytes = 0, total_bytes = 0;
  int         cs_low_cnt = 0, cs_high_cnt = 1000, low_cnt = 0, high_cnt = 0, max_high = 0;
  int         cmd_acc_cnt = 0, dat_acc_cnt = 0;
  exp_t       mon_e;
  burst_t     mon_b;

  always @(negedge sclk) begin
    cmd_fire_n = cmd_valid && cmd_ready;
    dat_fire_n = dat_valid && dat_ready;
    if (rst) begin
      in_burst = 1'b0; nbits = 0; nbytes = 0; expect_end = 1'b0;
      cs_high_cnt = 1000; prev_cs = 1'b1; prev_sck = 1'b1; prev_mosi = 1'b0;
    end else begin
      cs_fall  = prev_cs && !cs;
      cs_rise  = !prev_cs && cs;
      sck_rise = !prev_sck && spi_sck && !cs;
      sck_fall = prev_sck && !spi_sck && !cs;
      if (cs) cs_high_cnt++;
      if (cmd_fire_n) cmd_acc_cnt++;
      if (dat_fire_n) dat_acc_cnt++;

      if (cmd_ready || dat_ready) begin
        check_eq("one_ready", 32'(cmd_ready && dat_ready), 0);
        if (cs) check_eq("ready_after_gap", 32'(cs_high_cnt >= CS_GAP + 1), 1);
        else begin
          check_eq("ready_grant", 32'(dat_ready), 32'(burst_dc));
          check_eq("ready_in_next", 32'(spi_sck && nbits == 0 && nbytes > 0 && !expect_end), 1);
        end
      end

      if (cs_fall) begin
        check_eq("cs_gap", 32'(cs_high_cnt >= CS_GAP + 1), 1);
        cs_high_cnt = 0; cs_low_cnt = 1;
        in_burst = 1'b1; burst_dc = dc_c; nbits = 0; nbytes = 0;
        expect_end = 1'b0; max_high = 0; high_cnt = 1;
      end else if (!cs) cs_low_cnt++;

      if (in_burst && !cs && !cs_fall && !sck_fall && mosi !== prev_mosi)
        check_eq("mosi_change_on_fall", 32'(mosi), 32'(prev_mosi));

      if (sck_fall) begin
        check_eq("fall_after_last", 32'(expect_end), 0);
        if (nbytes == 0 && nbits == 0) check_eq("cs_setup", cs_low_cnt, CLK_DIV + 1);
        else if (nbits == 0) check_eq("next_spacing", 32'(high_cnt >= CLK_DIV + 1), 1);
        else check_eq("sck_high_w", high_cnt, CLK_DIV);
        if (high_cnt > max_high) max_high = high_cnt;
        low_cnt = 1;
      end else if (!cs && !spi_sck) low_cnt++;

      if (sck_rise) begin
        check_eq("sck_low_w", low_cnt, CLK_DIV);
        check_eq("dc_stable", 32'(dc_c), 32'(burst_dc));
        high_cnt = 1;
        shift = {shift[6:0], mosi};
        nbits++;
        if (nbits == 8) begin
          nbits = 0; nbytes++; total_bytes++;
          if (nbytes == 1) first_byte = shift;
          if (!burst_dc) begin
            check_eq("cmd_exp_avail", 32'(cmd_exp.size() > 0), 1);
            if (cmd_exp.size() > 0) begin
              mon_e = cmd_exp.pop_front();
              check_eq("cmd_byte", 32'(shift), 32'(mon_e.data));
              expect_end = mon_e.last;
            end
          end else begin
            check_eq("dat_exp_avail", 32'(dat_exp.size() > 0), 1);
            if (dat_exp.size() > 0) begin
              mon_e = dat_exp.pop_front();
              check_eq("dat_byte", 32'(shift), 32'(mon_e.data));
              expect_end = mon_e.last;
            end
          end
        end
      end else if (!cs && spi_sck && !cs_fall) high_cnt++;

      if (cs_rise && in_burst) begin
        check_eq("burst_end_on_last", 32'(expect_end), 1);
        check_eq("burst_whole_bytes", nbits, 0);
        mon_b.dc = burst_dc; mon_b.nbytes = nbytes; mon_b.cs_low = cs_low_cnt;
        mon_b.first = first_byte; mon_b.max_high = max_high;
        burst_log.push_back(mon_b);
        in_burst = 1'b0;
      end

      prev_cs = cs; prev_sck = spi_sck; prev_mosi = mosi;
    end
  end

  task automatic wait_idle(input int budget);
    int   quiet = 0;
    logic done  = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge sclk);
      if (cmd_drv.size() == 0 && dat_drv.size() == 0 && !cmd_valid && !dat_valid && !busy && cs)
        quiet++;
      else
        quiet = 0;
      if (quiet >= 3) done = 1'b1;
    end
    check_eq("idle_reached", 32'(done), 1);
  endtask

  task automatic wait_bytes(input int n, input int budget);
    logic done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge sclk);
      if (in_burst && nbytes >= n) done = 1'b1;
    end
    check_eq("bytes_reached", 32'(done), 1);
  endtask

  task automatic check_burst(input string tag, input int idx, input logic dc,
                             input int nb, input logic [7:0] first);
    check_eq({tag, "_logged"}, 32'(burst_log.size() > idx), 1);
    if (burst_log.size() > idx) begin
      check_eq({tag, "_dc"}, 32'(burst_log[idx].dc), 32'(dc));
      check_eq({tag, "_nbytes"}, burst_log[idx].nbytes, nb);
      check_eq({tag, "_first"}, 32'(burst_log[idx].first), 32'(first));
    end
  endtask

  initial begin
    int b0, c0, d0, total;
    logic rst_ok;

    // Reset state.
    repeat (3) @(posedge sclk);
    @(negedge sclk);
    check_eq("rst_cs", 32'(cs), 1);
    check_eq("rst_sck", 32'(spi_sck), 1);
    check_eq("rst_mosi", 32'(mosi), 0);
    check_eq("rst_dc", 32'(dc_c), 0);
    check_eq("rst_cmd_ready", 32'(cmd_ready), 0);
    check_eq("rst_dat_ready", 32'(dat_ready), 0);
    check_eq("rst_busy", 32'(busy), 0);
    @(posedge sclk); #1 rst = 1'b0;
    repeat (3) @(posedge sclk);

    // 1: single command byte 0xAF.
    b0 = burst_log.size(); c0 = cmd_acc_cnt;
    push_item(0, 8'hAF, 1'b1, 0);
    wait_idle(400);
    check_burst("t1", b0, 1'b0, 1, 8'hAF);
    if (burst_log.size() > b0) check_eq("t1_cs_low", burst_log[b0].cs_low, CLK_DIV + 16 * CLK_DIV);
    check_eq("t1_cmd_ready_pulses", cmd_acc_cnt - c0, 1);

    // 2: both requesters valid in the same IDLE cycle; command wins.
    b0 = burst_log.size(); d0 = dat_acc_cnt;
    push_item(0, 8'h3C, 1'b1, 0);
    push_item(1, 8'hC3, 1'b1, 0);
    wait_idle(400);
    check_burst("t2a", b0, 1'b0, 1, 8'h3C);
    check_burst("t2b", b0 + 1, 1'b1, 1, 8'hC3);
    check_eq("t2_dat_ready_pulses", dat_acc_cnt - d0, 1);

    // 3: three-byte pixel burst with a command arriving mid-burst.
    b0 = burst_log.size();
    push_item(1, 8'h12, 1'b0, 0);
    push_item(1, 8'h34, 1'b0, 0);
    push_item(1, 8'h56, 1'b1, 0);
    wait_bytes(1, 400);
    push_item(0, 8'h77, 1'b1, 0);
    wait_idle(600);
    check_burst("t3a", b0, 1'b1, 3, 8'h12);
    check_burst("t3b", b0 + 1, 1'b0, 1, 8'h77);

    // 4: command burst stalls 20 cycles between bytes while pixel data waits.
    b0 = burst_log.size();
    push_item(0, 8'hA5, 1'b0, 0);
    push_item(1, 8'hEE, 1'b1, 0);
    wait_bytes(1, 400);
    for (int i = 0; i < 20; i++) begin
      @(negedge sclk);
      check_eq("t4_hold_cs", 32'(cs), 0);
      check_eq("t4_hold_sck", 32'(spi_sck), 1);
      check_eq("t4_no_dat_ready", 32'(dat_ready), 0);
    end
    @(posedge sclk);
    push_item(0, 8'h5A, 1'b1, 0);
    wait_idle(600);
    check_burst("t4a", b0, 1'b0, 2, 8'hA5);
    check_burst("t4b", b0 + 1, 1'b1, 1, 8'hEE);
    if (burst_log.size() > b0) check_eq("t4_stall_seen", 32'(burst_log[b0].max_high >= 20), 1);

    // 5: reset in the middle of a byte, then a clean transfer.
    push_item(0, 8'h81, 1'b1, 0);
    rst_ok = 1'b0;
    for (int i = 0; i < 400 && !rst_ok; i++) begin
      @(posedge sclk);
      if (in_burst && nbytes == 0 && nbits == 3) rst_ok = 1'b1;
    end
    check_eq("t5_bit4_reached", 32'(rst_ok), 1);
    #1 rst = 1'b1;
    @(posedge sclk);
    @(negedge sclk);
    check_eq("t5_cs", 32'(cs), 1);
    check_eq("t5_sck", 32'(spi_sck), 1);
    check_eq("t5_mosi", 32'(mosi), 0);
    check_eq("t5_busy", 32'(busy), 0);
    @(posedge sclk); #1 rst = 1'b0;
    cmd_exp.delete();
    dat_exp.delete();
    b0 = burst_log.size();
    push_item(0, 8'hC6, 1'b1, 0);
    wait_idle(400);
    check_burst("t5", b0, 1'b0, 1, 8'hC6);

    // 6: random bursts on both channels, 1000 bytes.
    total = 0;
    c0 = total_bytes;
    while (total < 1000) begin
      int ch, len;
      ch  = int'($urandom_range(0, 1));
      len = int'($urandom_range(1, 5));
      for (int i = 0; i < len; i++) begin
        push_item(ch, 8'($urandom), 1'(i == len - 1),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 24)) : 0);
        total++;
      end
    end
    wait_idle(70000);
    check_eq("t6_cmd_drained", cmd_exp.size(), 0);
    check_eq("t6_dat_drained", dat_exp.size(), 0);
    check_eq("t6_bytes_seen", total_bytes - c0, total);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
